// File: rtl/frog_status_if.sv
// frog_status_if
//   Groups the frame/mode strobes from game control, the per-frog collision
//   and goal flags from the sprite logic, and the life/goal/animation
//   outputs of frog_status into one bundle.
//   master : game-control / sprite side (drives strobes and flags)
//   slave  : frog_status side (drives Life1/2, frogwins, respawnN, dyingN)
interface frog_status_if;
  logic       frame_tick;
  logic       startx;
  logic       stage1x;
  logic       stage2x;
  logic       holdx;
  logic       player2;
  logic       winreset;
  logic       collide1;
  logic       collide2;
  logic       at_goal1;
  logic       at_goal2;
  logic [3:0] Life1;
  logic [3:0] Life2;
  logic       frogwins;
  logic       respawn1;
  logic       respawn2;
  logic       dying1;
  logic       dying2;

  modport master (
    output frame_tick, startx, stage1x, stage2x, holdx, player2, winreset,
           collide1, collide2, at_goal1, at_goal2,
    input  Life1, Life2, frogwins, respawn1, respawn2, dying1, dying2
  );

  modport slave (
    input  frame_tick, startx, stage1x, stage2x, holdx, player2, winreset,
           collide1, collide2, at_goal1, at_goal2,
    output Life1, Life2, frogwins, respawn1, respawn2, dying1, dying2
  );
endinterface

// File: rtl/frog_status.sv
// frog_status
//   Per-player life and goal tracker. Each frog runs a small FSM through a
//   timed death animation, respawn and a post-respawn grace window; lives
//   and the sticky frogwins flag feed the game-control state machine.
//   Ports:
//     Clk      system clock
//     Reset    asynchronous, active-high reset
//     io_frog  frog_status_if.slave: strobes/flags in, Life1/2, frogwins,
//              respawn1/2, dying1/2 out (all outputs registered)
//
//   state | meaning
//   ALIVE | frog playable, collisions and goals count
//   DYING | death animation, DEATH_FRAMES frame ticks
//   GRACE | respawned, collisions ignored for GRACE_FRAMES ticks
//   DEAD  | out of lives, absorbing until startx or Reset
module frog_status #(
  parameter int START_LIVES  = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int GRACE_FRAMES = 30
) (
  input logic           Clk,
  input logic           Reset,
  frog_status_if.slave  io_frog
);

  localparam int MAXF = (DEATH_FRAMES > GRACE_FRAMES) ? DEATH_FRAMES : GRACE_FRAMES;
  localparam int CW   = $clog2(MAXF + 1);

  typedef enum logic [1:0] {ALIVE, DYING, GRACE, DEAD} state_t;

  state_t          r_state [2];
  logic [CW-1:0]   r_cnt   [2];
  logic [3:0]      r_life  [2];
  logic [1:0]      r_respawn;
  logic            r_frogwins;
  logic            r_winreset_d;

  state_t          w_state_nxt   [2];
  logic [CW-1:0]   w_cnt_nxt     [2];
  logic [3:0]      w_life_nxt    [2];
  logic [1:0]      w_respawn_nxt;
  logic [1:0]      w_goal;
  logic            w_frogwins_nxt;
  logic            w_play;
  logic            w_adv;
  logic            w_wr_rise;
  logic [1:0]      w_en;
  logic [1:0]      w_collide;
  logic [1:0]      w_at_goal;

  assign w_play    = (io_frog.stage1x | io_frog.stage2x) & ~io_frog.holdx;
  assign w_adv     = w_play & io_frog.frame_tick;
  assign w_wr_rise = io_frog.winreset & ~r_winreset_d;
  assign w_en      = {io_frog.player2, 1'b1};
  assign w_collide = {io_frog.collide2, io_frog.collide1};
  assign w_at_goal = {io_frog.at_goal2, io_frog.at_goal1};

  always_comb begin
    w_respawn_nxt = '0;
    w_goal        = '0;
    for (int i = 0; i < 2; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_life_nxt[i]  = r_life[i];
      if (io_frog.startx) begin
        w_state_nxt[i] = ALIVE;
        w_cnt_nxt[i]   = '0;
        w_life_nxt[i]  = 4'(START_LIVES);
      end else if (io_frog.winreset) begin
        // Held winreset keeps live frogs parked in ALIVE; respawn only on the edge.
        if (r_state[i] != DEAD) begin
          w_state_nxt[i]   = ALIVE;
          w_cnt_nxt[i]     = '0;
          w_respawn_nxt[i] = w_wr_rise;
        end
      end else begin
        case (r_state[i])
          ALIVE: begin
            if (w_collide[i] & w_play & w_en[i]) begin
              // Collision beats a same-cycle goal.
              w_state_nxt[i] = DYING;
              w_cnt_nxt[i]   = '0;
              w_life_nxt[i]  = (r_life[i] == 4'd0) ? 4'd0 : r_life[i] - 4'd1;
            end else if (w_at_goal[i] & w_play & w_en[i]) begin
              w_goal[i] = 1'b1;
            end
          end
          DYING: begin
            if (w_adv) begin
              if (r_cnt[i] == CW'(DEATH_FRAMES - 1)) begin
                w_cnt_nxt[i] = '0;
                if (r_life[i] == 4'd0) begin
                  w_state_nxt[i] = DEAD;
                end else begin
                  w_state_nxt[i]   = GRACE;
                  w_respawn_nxt[i] = 1'b1;
                end
              end else begin
                w_cnt_nxt[i] = r_cnt[i] + CW'(1);
              end
            end
          end
          GRACE: begin
            if (w_at_goal[i] & w_play & w_en[i]) w_goal[i] = 1'b1;
            if (w_adv) begin
              if (r_cnt[i] == CW'(GRACE_FRAMES - 1)) begin
                w_state_nxt[i] = ALIVE;
                w_cnt_nxt[i]   = '0;
              end else begin
                w_cnt_nxt[i] = r_cnt[i] + CW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end

    if (io_frog.startx | io_frog.winreset) w_frogwins_nxt = 1'b0;
    else if (|w_goal)                      w_frogwins_nxt = 1'b1;
    else                                   w_frogwins_nxt = r_frogwins;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= ALIVE;
        r_cnt[i]   <= '0;
        r_life[i]  <= 4'(START_LIVES);
      end
      r_respawn    <= '0;
      r_frogwins   <= 1'b0;
      r_winreset_d <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        r_life[i]  <= w_life_nxt[i];
      end
      r_respawn    <= w_respawn_nxt;
      r_frogwins   <= w_frogwins_nxt;
      r_winreset_d <= io_frog.winreset;
    end
  end

  assign io_frog.Life1    = r_life[0];
  assign io_frog.Life2    = r_life[1];
  assign io_frog.frogwins = r_frogwins;
  assign io_frog.respawn1 = r_respawn[0];
  assign io_frog.respawn2 = r_respawn[1];
  assign io_frog.dying1   = (r_state[0] == DYING);
  assign io_frog.dying2   = (r_state[1] == DYING);

endmodule
